// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction-memory
// boot loader (imem_loader and its word_assembler sub-module).
//   state_t    - loader FSM states
//   LEN_BYTES  - bytes in the big-endian word-count header
//   WORD_BYTES - bytes per instruction word
//   CSUM_W     - width of the running data checksum
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CSUM,
        DONE,
        ERROR
    } state_t;

    localparam int unsigned LEN_BYTES  = 2;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned CSUM_W     = 8;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// word_assembler: packs a byte stream into big-endian 32-bit words.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   clear       - synchronous clear of the partial word and byte counter
//   in_valid    - in_data is a byte to consume this cycle
//   in_data     - input byte (first byte of a word is the MSB)
//   byte_cnt    - number of bytes already held for the current word
//   word_valid  - one-cycle pulse, the cycle after a word's 4th byte
//   word        - last completed word; holds until the next one completes
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic [1:0]  byte_cnt,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [23:0] shift_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q    <= '0;
            byte_cnt   <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                shift_q  <= '0;
                byte_cnt <= '0;
            end else if (in_valid) begin
                if (byte_cnt == 2'(WORD_BYTES - 1)) begin
                    word       <= {shift_q, in_data};
                    word_valid <= 1'b1;
                    byte_cnt   <= '0;
                end else begin
                    shift_q  <= {shift_q[15:0], in_data};
                    byte_cnt <= byte_cnt + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that streams a program into the
// instruction memory of the single-cycle MIPS core while holding it in reset.
// Frame: 2-byte word count N (MSB first), 4*N data bytes (big-endian words),
// then one checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   start             - begins a load (only from IDLE, DONE, ERROR)
//   s_valid/s_data    - input byte stream; s_ready = loader accepts a byte
//   wr_en_ins         - instruction memory write strobe (one cycle per word)
//   wr_addr, wr_data  - word-aligned byte address and word; hold last value
//   cpu_rst           - core reset, released only in DONE
//   done, error       - level status of the last load
// Parameters: ADDR_W (address width), DEPTH_WORDS (memory capacity in words).
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              wr_en_ins,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_rst,
    output logic              done,
    output logic              error
);

    state_t            state_q, state_d;
    logic              s_ready_d;
    logic [7:0]        len_hi_q;
    logic              len_cnt_q;
    logic [15:0]       n_words_q;
    logic [15:0]       idx_q;
    logic [1:0]        byte_cnt;
    logic [15:0]       len_word;
    logic              accept;
    logic              start_ok;
    logic              last_byte;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [CSUM_W-1:0] sum_q;
`endif

    assign accept    = s_valid && s_ready;
    assign len_word  = {len_hi_q, s_data};
    assign start_ok  = start && (state_q inside {IDLE, DONE, ERROR});
    assign last_byte = accept && (state_q == DATA)
                       && (byte_cnt == 2'(WORD_BYTES - 1))
                       && (idx_q == n_words_q - 16'd1);

    word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_ok),
        .in_valid   (accept && (state_q == DATA)),
        .in_data    (s_data),
        .byte_cnt   (byte_cnt),
        .word_valid (wr_en_ins),
        .word       (wr_data)
    );

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        error   = 1'b0;
        cpu_rst = 1'b1;
        case (state_q)
            IDLE: if (start) state_d = LEN;
            LEN: begin
                if (accept && (len_cnt_q == 1'(LEN_BYTES - 1))) begin
                    if (len_word == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = CSUM;
`else
                        state_d = DONE;
`endif
                    end else if (32'(len_word) > DEPTH_WORDS) begin
                        state_d = ERROR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (last_byte) state_d = CSUM;
`else
                // Wait for the final write pulse so done follows it by a cycle.
                if (idx_q == n_words_q) state_d = DONE;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                if (accept) state_d = (CSUM_W'(sum_q + s_data) == '0) ? DONE : ERROR;
            end
`endif
            DONE: begin
                done    = 1'b1;
                cpu_rst = 1'b0;
                if (start) state_d = LEN;
            end
            ERROR: begin
                error = 1'b1;
                if (start) state_d = LEN;
            end
            default: state_d = IDLE;
        endcase
        // s_ready drops right after the last data byte when no checksum follows.
        s_ready_d = (state_d inside {LEN, DATA, CSUM});
`ifndef IMEM_LOADER_CHECKSUM_EN
        if (last_byte) s_ready_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            s_ready   <= 1'b0;
            len_hi_q  <= '0;
            len_cnt_q <= 1'b0;
            n_words_q <= '0;
            idx_q     <= '0;
            wr_addr   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            s_ready <= s_ready_d;
            if (start_ok) begin
                len_cnt_q <= 1'b0;
                idx_q     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum_q     <= '0;
`endif
            end else if (accept) begin
                if (state_q == LEN) begin
                    len_cnt_q <= ~len_cnt_q;
                    if (len_cnt_q == 1'b0) len_hi_q <= s_data;
                    else n_words_q <= len_word;
                end else if (state_q == DATA) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_q <= sum_q + s_data;
`endif
                    if (byte_cnt == 2'(WORD_BYTES - 1)) begin
                        wr_addr <= ADDR_W'({idx_q, 2'b00});
                        idx_q   <= idx_q + 16'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst, start, s_valid;
    logic [7:0]  s_data;
    logic        s_ready, wr_en_ins, cpu_rst, done, error;
    logic [31:0] wr_addr, wr_data;

    imem_loader #(.ADDR_W(32), .DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .wr_en_ins(wr_en_ins), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_rst(cpu_rst), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] addr; logic [31:0] data; int c; } wr_t;
    wr_t wq[$];
    always @(negedge clk) if (wr_en_ins) wq.push_back('{wr_addr, wr_data, cyc});

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] frame_words[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps, output int t_acc);
        t_acc = -1;
        for (int k = 0; k < 64; k++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                s_valid = 1'b0;
                s_data  = 8'($urandom);
                @(posedge clk); #1;
            end else begin
                s_valid = 1'b1;
                s_data  = b;
                if (s_ready) begin
                    t_acc = cyc;
                    @(posedge clk); #1;
                    s_valid = 1'b0;
                    s_data  = 8'($urandom);
                    return;
                end
                @(posedge clk); #1;
            end
        end
        s_valid = 1'b0;
        n_cmp++;
        n_bad++;
        $display("FAIL handshake timeout: s_ready got 0 expected 1");
    endtask

    // Reference: writes go to 4*i with frame_words[i]; status from length/checksum rules.
    task automatic run_frame(input int n, input bit gaps, input bit bad_cs,
                             input bit exp_done, input bit exp_err, input string tag);
        logic [15:0] hdr;
        logic [31:0] w;
        logic [7:0]  sum, b;
        int          t;
        hdr = 16'(n);
        sum = 8'd0;
        wq.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " start done"}, 64'(done), 64'd0);
        check({tag, " start error"}, 64'(error), 64'd0);
        check({tag, " start cpu_rst"}, 64'(cpu_rst), 64'd1);
        send_byte(hdr[15:8], gaps, t);
        send_byte(hdr[7:0], gaps, t);
        if (n > DEPTH) begin
            check({tag, " lenerr error"}, 64'(error), 64'(exp_err));
            check({tag, " lenerr cpu_rst"}, 64'(cpu_rst), 64'd1);
            repeat (3) @(posedge clk);
            #1;
            check({tag, " lenerr writes"}, 64'(wq.size()), 64'd0);
            check({tag, " lenerr cpu_rst hold"}, 64'(cpu_rst), 64'd1);
            return;
        end
        for (int i = 0; i < n; i++) begin
            w = frame_words[i];
            for (int k = 0; k < 4; k++) begin
                b = w[31 - 8*k -: 8];
                sum = sum + b;
                send_byte(b, gaps, t);
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        b = 8'd0 - sum;
        if (bad_cs) b = b + 8'd1;
        send_byte(b, gaps, t);
`else
        if (n > 0) begin
            check({tag, " T+1 done"}, 64'(done), 64'd0);
            check({tag, " T+1 cpu_rst"}, 64'(cpu_rst), 64'd1);
            @(posedge clk); #1;
        end
`endif
        check({tag, " final done"}, 64'(done), 64'(exp_done));
        check({tag, " final error"}, 64'(error), 64'(exp_err));
        check({tag, " final cpu_rst"}, 64'(cpu_rst), 64'(!exp_done));
        check({tag, " write count"}, 64'(wq.size()), 64'(n));
        for (int i = 0; i < n && i < wq.size(); i++) begin
            check({tag, " wr_addr"}, 64'(wq[i].addr), 64'(4 * i));
            check({tag, " wr_data"}, 64'(wq[i].data), 64'(frame_words[i]));
        end
`ifndef IMEM_LOADER_CHECKSUM_EN
        if (n > 0 && wq.size() == n)
            check({tag, " last write cycle"}, 64'(wq[n-1].c), 64'(t + 1));
`endif
    endtask

    task automatic fill_words(input int n, input int seed);
        frame_words.delete();
        if (seed == 0) begin
            frame_words.push_back(32'h20080005);
            frame_words.push_back(32'h01095020);
        end else begin
            for (int i = 0; i < n; i++) frame_words.push_back(32'h9E3779B9 * (i + seed) ^ 32'(seed));
        end
    endtask

    typedef struct { int n; int seed; bit gaps; bit exp_done; bit exp_error; } vec_t;
    vec_t tbl[7];

    initial begin
        int t;
        bit bad;
        int n;
        #900000;
        $display("FAIL watchdog: time limit reached, summary follows");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, n;
        bit bad, g;
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset s_ready", 64'(s_ready), 64'd0);
        check("reset wr_en_ins", 64'(wr_en_ins), 64'd0);
        check("reset wr_addr", 64'(wr_addr), 64'd0);
        check("reset wr_data", 64'(wr_data), 64'd0);
        check("reset cpu_rst", 64'(cpu_rst), 64'd1);
        check("reset done", 64'(done), 64'd0);
        check("reset error", 64'(error), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        tbl[0] = '{2,     0, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{2,     0, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{257,   1, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{0,     1, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{256,   5, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{3,     7, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{65535, 2, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            fill_words(tbl[i].n, tbl[i].seed);
            run_frame(tbl[i].n, tbl[i].gaps, 1'b0, tbl[i].exp_done, tbl[i].exp_error,
                      $sformatf("vec%0d", i));
        end

        // Reset in the middle of the second data word.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        send_byte(8'h00, 1'b0, t);
        send_byte(8'h04, 1'b0, t);
        for (int i = 0; i < 6; i++) send_byte(8'(8'hA0 + i), 1'b0, t);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst s_ready", 64'(s_ready), 64'd0);
        check("midrst wr_en_ins", 64'(wr_en_ins), 64'd0);
        check("midrst wr_addr", 64'(wr_addr), 64'd0);
        check("midrst wr_data", 64'(wr_data), 64'd0);
        check("midrst cpu_rst", 64'(cpu_rst), 64'd1);
        check("midrst done", 64'(done), 64'd0);
        check("midrst error", 64'(error), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        fill_words(2, 0);
        run_frame(2, 1'b0, 1'b0, 1'b1, 1'b0, "after_rst");
        fill_words(4, 11);
        run_frame(4, 1'b1, 1'b0, 1'b1, 1'b0, "reload");

`ifdef IMEM_LOADER_CHECKSUM_EN
        frame_words.delete();
        frame_words.push_back(32'h00000001);
        run_frame(1, 1'b0, 1'b0, 1'b1, 1'b0, "csum_ok");
        run_frame(1, 1'b0, 1'b1, 1'b0, 1'b1, "csum_bad");
`endif

        for (int r = 0; r < 12; r++) begin
            n = ($urandom_range(0, 7) == 0) ? 256 + $urandom_range(1, 40) : $urandom_range(0, 6);
            g = 1'($urandom_range(0, 1));
`ifdef IMEM_LOADER_CHECKSUM_EN
            bad = ($urandom_range(0, 3) == 0);
`else
            bad = 1'b0;
`endif
            frame_words.delete();
            for (int i = 0; i < n && i <= DEPTH; i++) frame_words.push_back($urandom);
            run_frame(n, g, bad, !(n > DEPTH || bad), (n > DEPTH || bad), $sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
